// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - serial NOR flash read responder (0xAB wake, 0x03 read) with backdoor-loaded array
// SPI pins are oversampled on CLK; all state updates on synchronized SCK edges.
module spi_flash_responder #(
  parameter int MEM_AW      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              SPI_SCK,
  input  logic              SPI_CS,
  input  logic              SPI_SI,
  output logic              SPI_SO,
  input  logic              mem_we,
  input  logic [MEM_AW-1:0] mem_waddr,
  input  logic [7:0]        mem_wdata,
  output logic              awake,
  output logic              rd_active,
  output logic [23:0]       cmd_addr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] OP_WAKE = 8'hAB;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  logic [7:0] mem_q [2**MEM_AW];

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] si_sync_q, si_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [22:0]            shift_q, shift_d;
  logic [MEM_AW-1:0]      addr_q, addr_d;
  logic [7:0]             byte_q, byte_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   so_q, so_d;
  logic                   awake_q, awake_d;
  logic                   rd_active_q, rd_active_d;
  logic [23:0]            cmd_addr_q, cmd_addr_d;

  logic              sck_s, cs_s, si_s;
  logic              sample_ev, shift_ev;
  logic [23:0]       in_word;
  logic [MEM_AW-1:0] addr_inc;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign si_s      = si_sync_q[SYNC_STAGES-1];
  assign sample_ev = sck_s & ~sck_prev_q;
  assign shift_ev  = ~sck_s & sck_prev_q;
  assign in_word   = {shift_q, si_s};
  assign addr_inc  = addr_q + ADDR_ONE;

  always_comb begin
    state_d     = state_q;
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
    si_sync_d   = {si_sync_q[SYNC_STAGES-2:0], SPI_SI};
    sck_prev_d  = sck_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    byte_d      = byte_q;
    bit_idx_d   = bit_idx_q;
    so_d        = 1'b0;
    awake_d     = awake_q;
    rd_active_d = rd_active_q;
    cmd_addr_d  = cmd_addr_q;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 5'd0;
        if (!cs_s) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (sample_ev) begin
          shift_d   = in_word[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            if (in_word[7:0] == OP_WAKE) begin
              awake_d = 1'b1;
              state_d = ST_IGNORE;
            end else if (in_word[7:0] == OP_READ && awake_q) begin
              state_d = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
      end
      ST_ADDR: begin
        if (sample_ev) begin
          shift_d   = in_word[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d   = 5'd0;
            cmd_addr_d  = in_word;
            addr_d      = in_word[MEM_AW-1:0];
            byte_d      = mem_q[in_word[MEM_AW-1:0]];
            bit_idx_d   = 3'd7;
            rd_active_d = 1'b1;
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        so_d = so_q;
        if (shift_ev) begin
          so_d = byte_q[bit_idx_q];
          // Prefetch the next byte as bit 0 leaves so bit 7 is ready at the next fall.
          if (bit_idx_q == 3'd0) begin
            addr_d    = addr_inc;
            byte_d    = mem_q[addr_inc];
            bit_idx_d = 3'd7;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
          end
        end
      end
      default: ;
    endcase

    if (cs_s) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 5'd0;
      rd_active_d = 1'b0;
      so_d        = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      si_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
      bit_cnt_q   <= 5'd0;
      shift_q     <= '0;
      addr_q      <= '0;
      byte_q      <= 8'd0;
      bit_idx_q   <= 3'd7;
      so_q        <= 1'b0;
      awake_q     <= 1'b0;
      rd_active_q <= 1'b0;
      cmd_addr_q  <= 24'd0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      si_sync_q   <= si_sync_d;
      sck_prev_q  <= sck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      byte_q      <= byte_d;
      bit_idx_q   <= bit_idx_d;
      so_q        <= so_d;
      awake_q     <= awake_d;
      rd_active_q <= rd_active_d;
      cmd_addr_q  <= cmd_addr_d;
    end
  end

  // Backdoor array: never reset, so contents survive a mid-transfer reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign SPI_SO    = so_q;
  assign awake     = awake_q;
  assign rd_active = rd_active_q;
  assign cmd_addr  = cmd_addr_q;

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI flash responder: the device end of the serial flash read protocol used by `spi_controller`. It models the subset of a serial NOR flash that the CPU memory path uses: wake-up `0xAB` and read `0x03` with a 24-bit address. Data comes from an internal byte array that a backdoor port preloads. It sits in place of the physical flash in simulation and on-chip test builds. It oversamples the SPI pins with the system clock.

## Interface
Parameters:
- `MEM_AW`, default 16: byte-address width of the internal array (2^MEM_AW bytes).
- `SYNC_STAGES`, default 2: synchronizer depth on `SPI_SCK`, `SPI_CS` and `SPI_SI`.

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `SPI_SCK`  in  1  serial clock from the controller, asynchronous to `CLK`.
- `SPI_CS`  in  1  chip select, active low.
- `SPI_SI`  in  1  serial data in from the controller, MSB first.
- `SPI_SO`  out  1  serial data out to the controller, MSB first.
- `mem_we`  in  1  backdoor byte write strobe.
- `mem_waddr`  in  MEM_AW  backdoor write address.
- `mem_wdata`  in  8  backdoor write data.
- `awake`  out  1  device has left power-down.
- `rd_active`  out  1  device is shifting read data out.
- `cmd_addr`  out  24  last latched read address (debug).

## Operation
- Edge detection: the synchronized SCK rising edge is the sample event; the synchronized falling edge is the shift event.
- A synchronized CS high forces state IDLE from any state and clears the bit counter.
- States:
  - IDLE: waits for synchronized CS low, then goes to CMD.
  - CMD: shifts in 8 bits on sample events. After the 8th bit:
    - `0xAB`: set `awake`, go to IGNORE.
    - `0x03` with `awake`=1: go to ADDR.
    - Any other opcode, or `0x03` while asleep: go to IGNORE.
  - ADDR: shifts in 24 bits. On the 24th sample event:
    - Latch `cmd_addr`.
    - Load the byte register with `mem[addr[MEM_AW-1:0]]`.
    - Set `rd_active`, go to DATA.
  - DATA: each shift event drives `SPI_SO` with the current byte bit, starting at bit 7.
    - After bit 0 is driven, the internal address increments modulo 2^MEM_AW.
    - The next byte is fetched in time for its bit 7 at the following shift event.
    - Bytes stream indefinitely until CS goes high.
  - IGNORE: discards all SCK activity until CS goes high.
- Address bits above `MEM_AW` are ignored, so the array aliases across the 24-bit space. `cmd_addr` keeps all 24 bits.
- `SPI_SO` is 0 in every state except DATA.
- `awake` stays set until `reset`. `0xAB` while already awake is harmless.
- Backdoor writes are accepted in any state. If a write and a data fetch hit the same address in the same cycle, the fetch returns the old byte.

## Timing
- Values after `reset`:
  - `SPI_SO`=0, `awake`=0, `rd_active`=0, `cmd_addr`=0.
  - State IDLE, counters 0.
  - Array contents are not cleared.
- Reset mid-transaction aborts immediately. The controller must raise CS, send `0xAB`, then resume reads.
- Pin-to-event latency is `SYNC_STAGES`+1 `CLK` cycles.
- SCK high and low phases must each be at least `SYNC_STAGES`+2 `CLK` cycles.
- The first data bit (bit 7 of `mem[addr]`) is valid from the shift event that follows the 32nd sample event. The controller samples it on the next SCK rise.
- `rd_active` rises in the cycle after the 32nd sample event. It falls in the cycle after synchronized CS goes high.
- `awake` rises in the cycle after the 8th sample event of `0xAB`.
- CS rising before 32 bits are received leaves `cmd_addr` unchanged and outputs nothing.
- Address wrap: a read streaming from 2^MEM_AW−1 continues at 0.

## Test plan
- Wake and read: preload `mem[0x0100..0x0103]`=`11 22 33 44`; send `AB`, CS high; then `03 00 01 00` plus 32 clocks. Required: controller word `0x11223344`, `cmd_addr`=`0x000100`.
- Read while asleep: after reset send `03 00 00 00` plus 32 clocks. Required: `SPI_SO`=0 throughout, `awake`=0, `rd_active`=0.
- Abort mid-address: awake; send `03 00`, then CS high. Then read `0x000004` with `mem[4..7]`=`DE AD BE EF`. Required: `DEADBEEF`, `cmd_addr` reads 0 between the two transfers.
- Wrap and alias: `mem[0xFFFE,0xFFFF,0,1]`=`A1 A2 A3 A4`; read 32 bits at `0x05FFFE`. Required: `A1A2A3A4`, `cmd_addr`=`0x05FFFE`.
- Unknown opcode: send `9F` plus 32 clocks. Required: `SPI_SO`=0, state stays IGNORE until CS high. A following read of `0x000100` then returns `0x11223344`.
- Reset mid-DATA: assert `reset` during the 10th data bit. Required: next cycle `SPI_SO`=0, `rd_active`=0, `awake`=0. Array contents remain intact and are readable after `AB`.
